// File: rtl/mod_mul_feeder.sv
// mod_mul_feeder: shift-and-add multiplier that feeds A*B and the modulus to a downstream divider
module mod_mul_feeder #(
    parameter int SIZE = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SIZE-1:0]   input_a_tdata,
    input  logic              input_a_tvalid,
    output logic              input_a_tready,
    input  logic [SIZE-1:0]   input_b_tdata,
    input  logic              input_b_tvalid,
    output logic              input_b_tready,
    input  logic [SIZE-1:0]   input_mod_tdata,
    input  logic              input_mod_tvalid,
    output logic              input_mod_tready,
    output logic [2*SIZE-1:0] output_dividen_tdata,
    output logic              output_dividen_tvalid,
    input  logic              output_dividen_tready,
    output logic [SIZE-1:0]   output_divisor_tdata,
    output logic              output_divisor_tvalid,
    input  logic              output_divisor_tready,
    output logic              error
);
    localparam int CW = $clog2(SIZE) + 1;
    localparam logic [CW-1:0] LAST = CW'(SIZE);
    typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;
    state_t state, state_next;
    logic [CW-1:0] cnt;
    logic [2*SIZE-1:0] acc, mcand;
    logic [SIZE-1:0] mplier, mod_q;
    logic rdy, fire, dvd_v_next, div_v_next;
    assign input_a_tready = rdy;
    assign input_b_tready = rdy;
    assign input_mod_tready = rdy;
    assign fire = state == IDLE && rdy && input_a_tvalid && input_b_tvalid && input_mod_tvalid;
    always_comb begin
        state_next = state;
        dvd_v_next = output_dividen_tvalid;
        div_v_next = output_divisor_tvalid;
        case (state)
            IDLE: state_next = fire && input_mod_tdata != '0 ? MUL : IDLE;
            MUL: begin
                state_next = cnt == LAST ? OUT : MUL;
                dvd_v_next = cnt == LAST;
                div_v_next = cnt == LAST;
            end
            OUT: begin
                dvd_v_next = output_dividen_tvalid && !output_dividen_tready;
                div_v_next = output_divisor_tvalid && !output_divisor_tready;
                state_next = !dvd_v_next && !div_v_next ? IDLE : OUT;
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
            mod_q <= '0;
            rdy <= 1'b0;
            error <= 1'b0;
            output_dividen_tdata <= '0;
            output_dividen_tvalid <= 1'b0;
            output_divisor_tdata <= '0;
            output_divisor_tvalid <= 1'b0;
        end else begin
            state <= state_next;
            output_dividen_tvalid <= dvd_v_next;
            output_divisor_tvalid <= div_v_next;
            // ready lags the return to IDLE by one cycle so it never rises on the completing edge
            rdy <= state == IDLE && state_next == IDLE;
            error <= fire && input_mod_tdata == '0;
            if (fire) begin
                mcand <= {{SIZE{1'b0}}, input_a_tdata};
                mplier <= input_b_tdata;
                mod_q <= input_mod_tdata;
                acc <= '0;
                cnt <= '0;
            end else if (state == MUL) begin
                if (cnt == LAST) begin
                    output_dividen_tdata <= acc;
                    output_divisor_tdata <= mod_q;
                    cnt <= '0;
                end else begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule
